sobel_window_gen: RTL
=====================

// Module: sobel_window_gen
// PURPOSE
//  Producer side of the 3x3 window interface consumed by sobel_calc. Accepts a raster
//  pixel stream, keeps the two previous image lines in line buffers, and emits one 3x3
//  window per interior pixel on d0_o..d8_o, qualified by done_o.
//  Sits between the grayscale pixel source and sobel_calc. Its d*_o/done_o drive that
//  block's d*_i/done_i directly.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line (>=3)
//  IMG_HEIGHT  480  lines per frame (>=3)
//  COL_W       10   column counter width, >= clog2(IMG_WIDTH)
//  ROW_W       9    row counter width, >= clog2(IMG_HEIGHT)
// PORTS
//  clk           in   1   single clock; all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  pix_i         in   8   grayscale pixel, raster order
//  pix_valid_i   in   1   pix_i accepted this cycle (no backpressure)
//  sof_i         in   1   start of frame; qualifies a pixel only when pix_valid_i=1
//  d0_o..d8_o    out  8   window: d0,d1,d2 = top row (oldest line), left->right;
//                          d3..d5 = middle row; d6..d8 = bottom row (current line)
//  done_o        out  1   d*_o hold a valid window this cycle
//  frame_done_o  out  1   1-cycle pulse after the last pixel of a frame
//  win_cnt_o     out  20  only with SOBEL_WIN_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; col=0, row=0, state=S_FILL. Line-buffer contents are not reset;
//   they are don't-care.
//  Accepted pixel (pix_valid_i=1) at (row,col), one clock edge:
//   top=lb1[col], mid=lb0[col] (read-before-write); lb1[col]<=mid; lb0[col]<=pix_i
//   d0<=d1 d1<=d2 d2<=top | d3<=d4 d4<=d5 d5<=mid | d6<=d7 d7<=d8 d8<=pix_i
//   done_o<=(state==S_RUN && col>=2); otherwise done_o<=0
//  Latency: window containing pixel (r,c) as d8 appears 1 cycle after acceptance.
//  Idle cycles (pix_valid_i=0): d*_o, counters and line buffers hold; done_o<=0.
//  Counters: col++ per accepted pixel, wraps IMG_WIDTH-1 -> 0 with row++.
//   Last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1): row,col <= 0, state <= S_FILL,
//   frame_done_o <= 1 next cycle.
//  FSM: S_FILL (rows 0-1, no windows) -> S_RUN on the wrap from row 1 to row 2.
//   S_RUN -> S_FILL on frame end or on sof_i.
//  Windows never straddle lines: cols 0,1 of each line shift into the window but do not
//   assert done_o. Windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
//  sof_i with pix_valid_i: the pixel is treated as (0,0) of a new frame. Counters and
//   state restart, and that pixel is written at col 0.
//   No frame_done_o if the previous frame was incomplete. sof_i without pix_valid_i: ignored.
//  Reset mid-frame: the next pixel is (0,0); no done_o until row 2, col 2.
//  Line buffers: 2 x IMG_WIDTH x 8 b, inferable as RAM (single read + write per cycle).
// CONFIGURATION
//  SOBEL_WIN_CNT_EN defined: adds win_cnt_o[19:0], which counts done_o pulses in the
//   current frame. It clears to 0 on reset and on a sof_i-qualified pixel.
//   It holds its final value after frame end until the next frame's first pixel.
//   Increments in the same cycle done_o asserts.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*4+col)
//  1. Reset, stream 16 pixels back-to-back with sof_i on first -> first done_o 1 cycle after
//     pixel 10: d0..d8 = 0,1,2,4,5,6,8,9,10. Exactly 4 done_o pulses (d8 = 10,11,14,15).
//     frame_done_o 1 cycle after pixel 15.
//  2. Same stream with pix_valid_i low every other cycle -> identical windows and count;
//     done_o never high in an idle cycle; d*_o stable during gaps.
//  3. Two frames back-to-back, second frame pixel = 100+index -> second frame emits 4 windows,
//     first d8=110, d0=100. No window mixes frame-1 data.
//  4. sof_i reasserted at pixel 6 of frame 1, then a full frame -> no frame_done_o for the
//     aborted frame; exactly 4 windows from the new frame.
//  5. rst for 1 cycle after pixel 12 -> all outputs 0 next cycle; subsequent 16-pixel frame
//     behaves as in test 1.
//  6. With SOBEL_WIN_CNT_EN: test 1 -> win_cnt_o steps 1,2,3,4 with done_o; holds 4 after the
//     frame; clears to 0 on the next sof_i pixel.

Source files
------------

// File: rtl/sobel_window_gen.sv
// 3x3 window producer for sobel_calc: two line buffers plus a 3x3 shift window, one window per interior pixel.
// Latency 1 cycle from pixel acceptance to window; no backpressure. Optional SOBEL_WIN_CNT_EN adds win_cnt_o.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_i,
  input  logic        pix_valid_i,
  input  logic        sof_i,
  output logic [7:0]  d0_o,
  output logic [7:0]  d1_o,
  output logic [7:0]  d2_o,
  output logic [7:0]  d3_o,
  output logic [7:0]  d4_o,
  output logic [7:0]  d5_o,
  output logic [7:0]  d6_o,
  output logic [7:0]  d7_o,
  output logic [7:0]  d8_o,
  output logic        done_o,
  output logic        frame_done_o
`ifdef SOBEL_WIN_CNT_EN
  ,
  output logic [19:0] win_cnt_o
`endif
);

  typedef enum logic {S_FILL, S_RUN} state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [7:0]       lb0 [IMG_WIDTH];
  logic [7:0]       lb1 [IMG_WIDTH];
  logic [COL_W-1:0] col, eff_col;
  logic [ROW_W-1:0] row, eff_row;
  state_t           state, eff_state;
  logic [7:0]       top, mid;
  logic             win_ok;

  // A sof-qualified pixel is position (0,0) of a fresh frame regardless of counter state.
  always_comb begin
    eff_col   = sof_i ? '0 : col;
    eff_row   = sof_i ? '0 : row;
    eff_state = sof_i ? S_FILL : state;
    top       = lb1[eff_col];
    mid       = lb0[eff_col];
    win_ok    = (eff_state == S_RUN) && (eff_col >= COL_W'(2));
  end

  // Line buffers carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (pix_valid_i) begin
      lb1[eff_col] <= mid;
      lb0[eff_col] <= pix_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o} <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      col          <= '0;
      row          <= '0;
      state        <= S_FILL;
    end else begin
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      if (pix_valid_i) begin
        d0_o   <= d1_o;
        d1_o   <= d2_o;
        d2_o   <= top;
        d3_o   <= d4_o;
        d4_o   <= d5_o;
        d5_o   <= mid;
        d6_o   <= d7_o;
        d7_o   <= d8_o;
        d8_o   <= pix_i;
        done_o <= win_ok;
        if (eff_col == COL_LAST) begin
          col <= '0;
          if (eff_row == ROW_LAST) begin
            row          <= '0;
            state        <= S_FILL;
            frame_done_o <= 1'b1;
          end else begin
            row   <= eff_row + ROW_W'(1);
            state <= (eff_row == ROW_W'(1)) ? S_RUN : eff_state;
          end
        end else begin
          col   <= eff_col + COL_W'(1);
          row   <= eff_row;
          state <= eff_state;
        end
      end
    end
  end

`ifdef SOBEL_WIN_CNT_EN
  // Cleared by the first pixel of any frame, so the final count is visible between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_o <= '0;
    end else if (pix_valid_i) begin
      if (eff_col == '0 && eff_row == '0)
        win_cnt_o <= '0;
      else if (win_ok)
        win_cnt_o <= win_cnt_o + 20'd1;
    end
  end
`endif

endmodule
